// File: rtl/mem_bus_if.sv
// Self-timed rdM/wrM + mfc memory bus interface with wait timeout and a req/done handshake.
// Define MFC_SYNC_EN to pass mfc through a 2-flop synchronizer before the FSM uses it.
module mem_bus_if #(
  parameter int DW      = 16,
  parameter int AW      = 16,
  parameter int TIMEOUT = 15,
  parameter int TW      = 8
) (
  input  logic          clk,
  input  logic          rstIn,
  input  logic          req_rd,
  input  logic          req_wr,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] rdata,
  output logic          rdM,
  output logic          wrM,
  output logic [AW-1:0] Abus,
  output logic [DW-1:0] Dout,
  output logic          Doe,
  input  logic [DW-1:0] Din,
  input  logic          mfc
);

  typedef enum logic [1:0] {IDLE, REQ, REL, FIN} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic          err_q, err_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          mfcUse;
  logic          timeoutHit;

`ifdef MFC_SYNC_EN
  logic [1:0] mfcSync_q;

  always_ff @(posedge clk or negedge rstIn) begin
    if (!rstIn) mfcSync_q <= 2'b00;
    else        mfcSync_q <= {mfcSync_q[0], mfc};
  end

  assign mfcUse = mfcSync_q[1];
`else
  assign mfcUse = mfc;
`endif

  assign timeoutHit = (TIMEOUT != 0) && (cnt_q == TW'(TIMEOUT));

  always_ff @(posedge clk or negedge rstIn) begin
    if (!rstIn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // mfc is checked before the timeout so a late response still completes the cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_rd ^ req_wr) begin
          addr_d  = req_addr;
          wr_d    = req_wr;
          err_d   = 1'b0;
          state_d = REQ;
          if (req_wr) wdata_d = req_wdata;
        end else if (req_rd && req_wr) begin
          err_d   = 1'b1;
          state_d = FIN;
        end
      end
      REQ: begin
        if (mfcUse) begin
          if (!wr_q) rdata_d = Din;
          state_d = REL;
        end else if (timeoutHit) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      REL: begin
        if (!mfcUse) state_d = FIN;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Strobes decode straight from the state register so reset drops them asynchronously.
  assign busy  = (state_q != IDLE);
  assign done  = (state_q == FIN);
  assign rdM   = (state_q == REQ) && !wr_q;
  assign wrM   = (state_q == REQ) && wr_q;
  assign Doe   = (state_q == REQ) && wr_q;
  assign err   = err_q;
  assign rdata = rdata_q;
  assign Abus  = addr_q;
  assign Dout  = wdata_q;

endmodule

// File: tb/tb_mem_bus_if.sv
// Self-checking bench for mem_bus_if: directed vector table, reset corner case and
// randomized transactions predicted by a transaction-level model (honours MFC_SYNC_EN).
module tb_mem_bus_if;

  localparam int TO = 15;
`ifdef MFC_SYNC_EN
  localparam int S = 2;
`else
  localparam int S = 0;
`endif

  logic        clk;
  logic        rstIn;
  logic        req_rd;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] rdata;
  logic        rdM;
  logic        wrM;
  logic [15:0] Abus;
  logic [15:0] Dout;
  logic        Doe;
  logic [15:0] Din;
  logic        mfc;

  int          errors = 0;
  int          checks = 0;
  string       curTag = "init";
  logic [15:0] expAbus = '0;
  logic [15:0] expDout = '0;
  logic [15:0] mdlRdata = '0;

  typedef struct {
    logic        isRd;
    logic        isWr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] din;
    int          dly;
    int          hold;
    bit          poke;
    int          expStrobes;
    logic        expErr;
    int          expDoneAt;
    logic [15:0] expRdata;
  } vec_t;

  vec_t vecs[9];

  mem_bus_if #(.DW(16), .AW(16), .TIMEOUT(TO), .TW(8)) dut (
    .clk(clk), .rstIn(rstIn), .req_rd(req_rd), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy), .done(done),
    .err(err), .rdata(rdata), .rdM(rdM), .wrM(wrM), .Abus(Abus),
    .Dout(Dout), .Doe(Doe), .Din(Din), .mfc(mfc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s.%s got=%0h expected=%0h", curTag, name, act, exp);
    end
  endtask

  task automatic idleGap(input int n);
    int hits = 0;
    mfc = 1'b0;
    repeat (n) begin
      if (rdM || wrM) hits++;
      @(posedge clk); @(negedge clk);
    end
    checkOutput("idleStrobe", hits, 0);
  endtask

  // Memory responder raises mfc dly cycles into the strobe, keeps it up while the
  // strobe is high, then holds it hold more cycles after the strobe drops.
  task automatic applyStimulus(input logic isRd, input logic isWr, input logic [15:0] addr,
                               input logic [15:0] wdata, input logic [15:0] din,
                               input int dly, input int hold, input bit poke,
                               input int expStrobes, input logic expErr,
                               input int expDoneAt, input logic [15:0] expRdata);
    int strobes = 0;
    int doneAt = -1;
    int doneCnt = 0;
    req_rd = isRd; req_wr = isWr; req_addr = addr; req_wdata = wdata;
    Din = din; mfc = 1'b0;
    @(posedge clk); @(negedge clk);
    req_rd = 1'b0; req_wr = 1'b0;
    if (isRd ^ isWr) begin
      checkOutput("errClear", err, 0);
      expAbus = addr;
      if (isWr) expDout = wdata;
    end
    while ((rdM || wrM) && strobes < TO + 8) begin
      if (strobes == 0) begin
        checkOutput("strobeDir", {rdM, wrM}, {isRd, isWr});
        checkOutput("Doe", Doe, isWr);
        checkOutput("AbusReq", Abus, addr);
        if (isWr) checkOutput("DoutReq", Dout, wdata);
      end
      mfc = (strobes >= dly);
      strobes++;
      @(posedge clk); @(negedge clk);
    end
    Din = ~din;
    checkOutput("strobeCycles", strobes, expStrobes);
    for (int r = 0; r <= expDoneAt + 2; r++) begin
      if (done) begin
        if (doneCnt == 0) begin
          doneAt = r;
          checkOutput("errAtDone", err, expErr);
        end
        doneCnt++;
      end
      mfc    = !expErr && (r < hold);
      req_rd = poke && (r == 1);
      @(posedge clk); @(negedge clk);
    end
    req_rd = 1'b0;
    checkOutput("doneCount", doneCnt, 1);
    checkOutput("doneAt", doneAt, expDoneAt);
    checkOutput("busyAfter", busy, 0);
    checkOutput("errHeld", err, expErr);
    checkOutput("rdata", rdata, expRdata);
    checkOutput("AbusHeld", Abus, expAbus);
    checkOutput("DoutHeld", Dout, expDout);
    checkOutput("DoeIdle", Doe, 0);
    idleGap(4);
  endtask

  initial begin
    int doneSeen;
    rstIn = 1'b0; req_rd = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    Din = '0; mfc = 1'b0;

    #2;
    curTag = "reset";
    checkOutput("resetOuts", {busy, done, err, rdM, wrM, Doe}, 0);
    checkOutput("resetBus", {rdata, Abus, Dout}, 0);
    @(negedge clk);
    rstIn = 1'b1;
    @(negedge clk);

    vecs[0] = '{1, 0, 16'h0020, 16'h0000, 16'h01F4, 3,  0, 0, 4 + S, 0, 1 + S, 16'h01F4};
    vecs[1] = '{0, 1, 16'h0010, 16'h000F, 16'hAAAA, 2,  0, 0, 3 + S, 0, 1 + S, 16'h01F4};
    vecs[2] = '{1, 0, 16'h0030, 16'h0000, 16'hBEEF, 99, 0, 0, 16,    1, 0,     16'h01F4};
    vecs[3] = '{1, 1, 16'h0040, 16'h1111, 16'h2222, 0,  0, 0, 0,     1, 0,     16'h01F4};
    vecs[4] = '{1, 0, 16'h0050, 16'h0000, 16'h1234, 0,  0, 0, 1 + S, 0, 1 + S, 16'h1234};
    vecs[5] = '{1, 0, 16'h0060, 16'h0000, 16'h5678, 1,  5, 1, 2 + S, 0, 6 + S, 16'h5678};
    vecs[6] = '{1, 0, 16'h0070, 16'h0000, 16'h9ABC, TO - S,     0, 0, 16, 0, 1 + S, 16'h9ABC};
    vecs[7] = '{0, 1, 16'h0080, 16'h3333, 16'h0000, TO - S + 1, 0, 0, 16, 1, 0,     16'h9ABC};
    vecs[8] = '{0, 1, 16'h0090, 16'h4444, 16'h0000, 0,  2, 0, 1 + S, 0, 3 + S, 16'h9ABC};

    for (int i = 0; i < 9; i++) begin
      curTag = $sformatf("vec%0d", i);
      applyStimulus(vecs[i].isRd, vecs[i].isWr, vecs[i].addr, vecs[i].wdata, vecs[i].din,
                    vecs[i].dly, vecs[i].hold, vecs[i].poke, vecs[i].expStrobes,
                    vecs[i].expErr, vecs[i].expDoneAt, vecs[i].expRdata);
    end

    // Reset pulled while the read is still waiting in REQ.
    curTag = "midReset";
    req_rd = 1'b1; req_addr = 16'h00A0; mfc = 1'b0;
    @(posedge clk); @(negedge clk);
    req_rd = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    checkOutput("rdMBefore", rdM, 1);
    rstIn = 1'b0;
    #1;
    checkOutput("asyncDrop", {rdM, wrM, Doe, busy}, 0);
    doneSeen = 0;
    repeat (3) begin
      if (done) doneSeen++;
      @(negedge clk);
    end
    checkOutput("noDone", doneSeen, 0);
    rstIn = 1'b1;
    checkOutput("resetBus", {rdata, Abus, Dout, 15'd0, err}, 0);
    expAbus = '0; expDout = '0; mdlRdata = '0;
    @(negedge clk);
    curTag = "afterReset";
    applyStimulus(1, 0, 16'h00B0, 16'h0000, 16'h4321, 2, 1, 0, 3 + S, 0, 2 + S, 16'h4321);
    mdlRdata = 16'h4321;

    for (int t = 0; t < 30; t++) begin
      logic        isRd, isWr, expErr;
      logic [15:0] addr, wdata, din;
      int          kind, dly, hold, expStrobes, expDoneAt;
      kind  = $urandom_range(0, 7);
      isRd  = (kind == 0) || (kind % 2 == 1);
      isWr  = (kind == 0) || (kind % 2 == 0);
      addr  = 16'($urandom);
      wdata = 16'($urandom);
      din   = 16'($urandom);
      dly   = $urandom_range(0, TO + 3);
      hold  = $urandom_range(0, 3);
      if (isRd && isWr) begin
        expStrobes = 0; expErr = 1'b1; expDoneAt = 0;
      end else if (dly + S <= TO) begin
        expStrobes = dly + S + 1; expErr = 1'b0; expDoneAt = hold + 1 + S;
        if (isRd) mdlRdata = din;
      end else begin
        expStrobes = TO + 1; expErr = 1'b1; expDoneAt = 0;
      end
      curTag = $sformatf("rand%0d", t);
      applyStimulus(isRd, isWr, addr, wdata, din, dly, hold, 0,
                    expStrobes, expErr, expDoneAt, mdlRdata);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
